// File: rtl/dm_stage.sv
// Data-memory unit for the MEM stage: configurable depth, byte/half/word loads
// with sign or zero extension, and masked stores. Requests use valid/ready and
// get a registered one-cycle response. Misaligned or out-of-range accesses
// fault without touching memory. Reset clears the array with a one-word-per-cycle
// sweep, so that no wide combinational clear is needed.
module dm_stage #(
  parameter int ADDR_W = 10,
  parameter bit LOG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_exc,
  output logic        busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic {INIT, IDLE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W:0]    clearCnt_q, clearCnt_d;
  logic [31:0]        mem_q [DEPTH];

  logic               rspValid_q;
  logic               rspExc_q;
  logic [31:0]        rspRdata_q, rspRdata_d;

  logic               accept;
  logic               fault;
  logic               clearWrite;
  logic               storeWrite;
  logic [ADDR_W-1:0]  wordIdx;
  logic [1:0]         lane;
  logic [31:0]        curWord;
  logic [31:0]        storeWord;
  logic [31:0]        loadData;
  logic [7:0]         loadByte;
  logic [15:0]        loadHalf;

  // State and clear-counter registers; reset always restarts the sweep at word 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      clearCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      clearCnt_q <= clearCnt_d;
    end
  end

  // Sweep control: clear one word per cycle, leave INIT once the counter overflows into its top bit
  always_comb begin
    state_d    = state_q;
    clearCnt_d = clearCnt_q;
    busy       = 1'b0;
    req_ready  = 1'b0;
    clearWrite = 1'b0;
    case (state_q)
      INIT: begin
        busy = 1'b1;
        if (clearCnt_q[ADDR_W]) begin
          state_d = IDLE;
        end else begin
          clearWrite = 1'b1;
          clearCnt_d = clearCnt_q + CNT_ONE;
        end
      end
      IDLE: begin
        req_ready = 1'b1;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Request decode: word index, byte lane, fault conditions and the write enable
  always_comb begin
    wordIdx    = req_addr[ADDR_W+1:2];
    lane       = req_addr[1:0];
    accept     = req_valid & req_ready;
    fault      = (req_size == 2'b11)
               | ((req_size == 2'b01) & req_addr[0])
               | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
               | (|req_addr[31:ADDR_W+2]);
    storeWrite = accept & req_we & ~fault;
    curWord    = mem_q[wordIdx];
  end

  // Merge store data into the addressed word, leaving untouched lanes as they were
  always_comb begin
    storeWord = curWord;
    case (req_size)
      2'b00: storeWord[{lane, 3'b000} +: 8] = req_wdata[7:0];
      2'b01: begin
        if (lane[1]) storeWord[31:16] = req_wdata[15:0];
        else         storeWord[15:0]  = req_wdata[15:0];
      end
      2'b10: storeWord = req_wdata;
      default: storeWord = curWord;
    endcase
  end

  // Extract the addressed lane and extend it; stores and faults respond with zero data
  always_comb begin
    loadByte = curWord[{lane, 3'b000} +: 8];
    loadHalf = lane[1] ? curWord[31:16] : curWord[15:0];
    case (req_size)
      2'b00:   loadData = req_signed ? {{24{loadByte[7]}}, loadByte} : {24'b0, loadByte};
      2'b01:   loadData = req_signed ? {{16{loadHalf[15]}}, loadHalf} : {16'b0, loadHalf};
      default: loadData = curWord;
    endcase
    rspRdata_d = (accept & ~req_we & ~fault) ? loadData : 32'b0;
  end

  // Response registers: one-cycle pulse after each accept, dropped by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rspValid_q <= 1'b0;
      rspExc_q   <= 1'b0;
      rspRdata_q <= '0;
    end else begin
      rspValid_q <= accept;
      rspExc_q   <= accept & fault;
      rspRdata_q <= rspRdata_d;
    end
  end

  // Memory array write port: sweep clears in INIT, committed stores in IDLE
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clearWrite) begin
        mem_q[clearCnt_q[ADDR_W-1:0]] <= '0;
      end else if (storeWrite) begin
        mem_q[wordIdx] <= storeWord;
      end
    end
  end

`ifndef SYNTHESIS
  // Store trace for simulation logs
  always @(posedge clk) begin
    if (LOG_EN && !reset && storeWrite) begin
      $display("%d@%h: *%h <= %h", $time, req_pc, req_addr, req_wdata);
    end
  end
`endif

  assign rsp_valid = rspValid_q;
  assign rsp_exc   = rspExc_q;
  assign rsp_rdata = rspRdata_q;

endmodule

// File: tb/tb_dm_stage.sv
// Scoreboard bench for dm_stage: a byte-addressed reference memory predicts
// each response when the request is driven; a separate monitor compares
// whenever the DUT presents rsp_valid.
module tb_dm_stage;

  localparam int AW    = 5;
  localparam int DEPTH = 2 ** AW;
  localparam int NBYTE = 4 * DEPTH;

  typedef struct {
    logic        exc;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWe = 1'b0;
  logic [1:0]  reqSize = 2'b10;
  logic        reqSigned = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic [31:0] reqPc = '0;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic        rspExc;
  logic        busy;

  logic [7:0]  modelBytes [NBYTE];
  rsp_t        expQ [$];
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;

  dm_stage #(.ADDR_W(AW), .LOG_EN(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_we     (reqWe),
    .req_size   (reqSize),
    .req_signed (reqSigned),
    .req_addr   (reqAddr),
    .req_wdata  (reqWdata),
    .req_pc     (reqPc),
    .rsp_valid  (rspValid),
    .rsp_rdata  (rspRdata),
    .rsp_exc    (rspExc),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Predict the response of one access from the byte-level reference memory
  task automatic applyStimulus(input bit we, input logic [1:0] size, input bit sgn,
                               input logic [31:0] addr, input logic [31:0] wdata);
    rsp_t r;
    int   n;
    logic [31:0] v;
    @(posedge clk);
    #1;
    checkOutput("readyBeforeIssue", {31'b0, reqReady}, 32'd1);
    reqValid  = 1'b1;
    reqWe     = we;
    reqSize   = size;
    reqSigned = sgn;
    reqAddr   = addr;
    reqWdata  = wdata;
    reqPc     = $urandom;
    r.exc  = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
             (size == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'(NBYTE));
    r.data = '0;
    if (!r.exc) begin
      n = 1 << size;
      if (we) begin
        for (int i = 0; i < n; i++) modelBytes[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = modelBytes[int'(addr) + i];
        if (sgn && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sgn && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        r.data = v;
      end
    end
    expQ.push_back(r);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    reqValid = 1'b0;
  endtask

  // Reset, hold garbage requests during the sweep, and measure the sweep length
  task automatic resetAndSweep();
    int  cycles;
    bit  done;
    @(posedge clk);
    #1;
    reset    = 1'b1;
    reqValid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("resetBusy", {31'b0, busy}, 32'd1);
    checkOutput("resetReady", {31'b0, reqReady}, 32'd0);
    checkOutput("resetRspValid", {31'b0, rspValid}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < NBYTE; i++) modelBytes[i] = 8'h00;
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < 4 * DEPTH + 20) begin
      @(posedge clk);
      #1;
      cycles++;
      if (reqReady) begin
        done     = 1'b1;
        reqValid = 1'b0;
      end else begin
        reqWe    = $urandom_range(0, 1);
        reqAddr  = $urandom_range(0, NBYTE - 1);
        reqWdata = $urandom;
      end
    end
    reqValid = 1'b0;
    checkOutput("sweepLength", cycles, DEPTH + 1);
    checkOutput("busyAfterSweep", {31'b0, busy}, 32'd0);
  endtask

  // Monitor: pop an expectation whenever a response is presented
  always @(negedge clk) begin
    rsp_t e;
    if (rspValid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedRsp", {31'b0, rspValid}, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("rspExc", {31'b0, rspExc}, {31'b0, e.exc});
        checkOutput("rspRdata", rspRdata, e.data);
      end
    end else if (!reset) begin
      checkOutput("idleRspZero", {31'b0, rspExc} | rspRdata, 32'd0);
    end
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;

    resetAndSweep();
    for (int w = 0; w < DEPTH; w++) applyStimulus(1'b0, 2'd2, 1'b0, 32'(4 * w), 32'h0);
    idle();

    // Byte stores and loads
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF_7F01);
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AB);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h12, 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h12, 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);

    // Half stores and loads
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h22, 32'hDEAD_8001);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

    // Faulting accesses followed by reads proving memory is unchanged
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h21, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 2'd2, 1'b0, 32'(NBYTE), 32'hFFFF_FFFF);
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h13, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h00, 32'h0);
    idle();

    // Back-to-back store then load of the same word
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h40, 32'h1234_5678);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);

    // Randomized mix, mostly aligned and in range
    for (int k = 0; k < 300; k++) begin
      r  = $urandom_range(0, 9);
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if (r == 0) begin
        a = $urandom;
      end else begin
        a = $urandom_range(0, NBYTE - 1);
        if (r < 8 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      end
      applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();

    // Mid-operation reset: the sweep must run again and clear the array
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midResetRspValid", {31'b0, rspValid}, 32'd0);
    checkOutput("midResetBusy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    resetAndSweep();
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'(NBYTE - 4), 32'h0);
    idle();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queueDrained", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dm_stage.md
# dm_stage

Parametrised data-memory unit for the MIPS datapath's MEM stage. It is the successor of the fixed 1K-word store-only-masked memory:
- word depth is configurable;
- loads support byte, halfword and word sizes with sign or zero extension;
- accesses use a valid/ready request with a registered one-cycle response;
- misaligned or out-of-range accesses raise an exception instead of corrupting memory;
- reset clears the array through a one-word-per-cycle init sweep, not a combinational loop.

## Interface
Parameters:
- ADDR_W, 10, word-address width; depth = 2**ADDR_W words of 32 bits.
- LOG_EN, 1, when 1 emit a store trace line per committed store.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low bits used for byte/half.
- req_pc  in  32  PC of the issuing instruction, trace only.
- rsp_valid  out  1  response for the request accepted last cycle.
- rsp_rdata  out  32  extended load data; 0 for stores and exceptions.
- rsp_exc  out  1  access faulted.
- busy  out  1  init sweep in progress.

## Operation
- **States:** INIT, IDLE.
  - reset (any state, any cycle) -> INIT with clear counter = 0.
  - INIT writes 0 to word[counter] each cycle and increments. After word 2**ADDR_W-1 is written, go to IDLE. Counter is ADDR_W+1 bits.
  - busy=1 and req_ready=0 in INIT; busy=0 and req_ready=1 in IDLE.
- **Accept:** req_valid & req_ready at a rising edge.
- **Word index:** req_addr[ADDR_W+1:2]. Byte lane: req_addr[1:0].
- **Exception on accept** if any of:
  - req_size=11;
  - half with addr[0]=1;
  - word with addr[1:0]≠00;
  - req_addr[31:ADDR_W+2]≠0.
  
  An exception never writes memory.
- **Store:** written at the accept edge.
  - Byte: lane addr[1:0] gets wdata[7:0].
  - Half: addr[1]=0 -> bits 15:0, addr[1]=1 -> bits 31:16, from wdata[15:0].
  - Word: full write.
  - Other bytes are unchanged.
- **Load:** the word is read at the accept edge and the selected lane is extracted.
  - Byte/half are extended per req_signed and registered into rsp_rdata.
  - Word ignores req_signed.
- **Trace:** if LOG_EN, each non-faulting store prints "%d@%h: *%h <= %h" with $time, req_pc, req_addr, req_wdata.

## Timing
- **Reset values:** req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, rsp_exc=0.
- **Init duration:** req_ready first rises 2**ADDR_W+1 cycles after reset deasserts, i.e. after the last clear edge.
- **Response latency:** rsp_valid=1 exactly one cycle after accept, for one cycle. rsp_rdata/rsp_exc are valid only while rsp_valid=1 and are 0 otherwise.
- **Throughput:** one request per cycle in IDLE, with no back-pressure after init.
- **Store then load, same word, back-to-back:** the load returns the new data.
- **reset during INIT or with a response pending:** the response is dropped (rsp_valid=0 next cycle) and the sweep restarts from word 0.
- req_valid during INIT is ignored and not queued.

## Test plan
- **Reset sweep (ADDR_W=4):** pulse reset, then hold req_valid=1.
  - Required: req_ready=0 for 17 cycles, then 1.
  - Loads of words 0..15 all return 0.
- **Byte store/load:**
  - Stores: sw 0x80FF7F01 @0x10; sb 0xAB @0x12.
  - Required loads: lw -> 0x80AB7F01; lb @0x12 -> 0xFFFFFFAB; lbu @0x12 -> 0x000000AB; lb @0x11 -> 0x0000007F.
- **Half store/load:** sh 0x8001 @0x22, then lh @0x22 and lhu @0x22.
  - Required: lh -> 0xFFFF8001; lhu -> 0x00008001; word 0x20 low half unchanged.
- **Faults:**
  - Each of these gives rsp_exc=1, rsp_rdata=0, and memory unchanged: lw @0x13; sh @0x21; size=11; addr=0x00001000 with ADDR_W=10.
- **Back-to-back:** sw 0x12345678 @0x40 followed next cycle by lw @0x40.
  - Required: rsp_valid on both following cycles, load data 0x12345678.
- **Mid-operation reset:** accept lw, assert reset the next cycle.
  - Required: rsp_valid=0, busy=1, and the full sweep repeats.
